// File: rtl/tt_vector_player.sv
// Harness-side driver for a tt_um_* style design: replays a small vector table into the
// design, compares its masked outputs, and reports pass/fail, error count and first failing index.
module tt_vector_player #(
  parameter int DEPTH        = 16,
  parameter int SETTLE       = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic                     dut_ena,
  output logic                     dut_rst_n,
  output logic [7:0]               dut_ui_in,
  output logic [7:0]               dut_uio_in,
  input  logic [7:0]               dut_uo_out,
  input  logic [7:0]               dut_uio_oe
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;
  localparam int CMAX = (SETTLE > RESET_CYCLES) ? SETTLE : RESET_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [NW-1:0] DEPTH_N     = NW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_e;

  // Valid/ready is not used here: start and abort are single-cycle strobes, a table write
  // is accepted on any edge where wr_en = 1 and busy = 0.

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   n_q, n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [7:0]      err_q, err_d;
  logic [AW-1:0]   fidx_q, fidx_d;
  logic            ena_q, ena_d;
  logic            drst_q, drst_d;
  logic [7:0]      ui_q, ui_d;
  logic [7:0]      uio_q, uio_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     cur_vec;
  logic [31:0]     nxt_vec;
  logic            vec_err;
  logic            last_vec;

  logic            unused_oe;
  assign unused_oe = ^dut_uio_oe;

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Vector layout: {ui[31:24], uio[23:16], expect[15:8], mask[7:0]}
  always_comb begin
    cur_vec  = mem_q[idx_q];
    nxt_vec  = mem_q[idx_q + AW'(1)];
    vec_err  = |((dut_uo_out ^ cur_vec[15:8]) & cur_vec[7:0]);
    last_vec = ({1'b0, idx_q} == (n_q - NW'(1)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    ena_d   = ena_q;
    drst_d  = drst_q;
    ui_d    = ui_q;
    uio_d   = uio_q;

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ena_d   = 1'b0;
      drst_d  = 1'b0;
      ui_d    = 8'h00;
      uio_d   = 8'h00;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_d  = 8'h00;
            fail_d = 1'b0;
            fidx_d = '0;
            if (num_vec == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RST;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              cnt_d   = '0;
              idx_d   = '0;
              n_d     = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
              ena_d   = 1'b1;
              drst_d  = 1'b0;
              ui_d    = 8'h00;
              uio_d   = 8'h00;
            end
          end
        end
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            // idx is already 0, so cur_vec is the first vector.
            state_d = S_APPLY;
            cnt_d   = '0;
            drst_d  = 1'b1;
            ui_d    = cur_vec[31:24];
            uio_d   = cur_vec[23:16];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_APPLY: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SAMPLE: begin
          if (vec_err) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
            if (!fail_q) begin
              fail_d = 1'b1;
              fidx_d = idx_q;
            end
          end
          if (last_vec) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
            idx_d   = idx_q + AW'(1);
            cnt_d   = '0;
            ui_d    = nxt_vec[31:24];
            uio_d   = nxt_vec[23:16];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 8'h00;
      fidx_q  <= '0;
      ena_q   <= 1'b0;
      drst_q  <= 1'b0;
      ui_q    <= 8'h00;
      uio_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      ena_q   <= ena_d;
      drst_q  <= drst_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign err_count  = err_q;
  assign fail_idx   = fidx_q;
  assign dut_ena    = ena_q;
  assign dut_rst_n  = drst_q;
  assign dut_ui_in  = ui_q;
  assign dut_uio_in = uio_q;

endmodule
